// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: stage addresses and controls in,
// stall/flush/forward controls, scoreboard state and event counters out.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] RA1D, RA2D, WA3D;
  logic [ADDR_W-1:0] RA1E, RA2E, WA3E;
  logic              MemtoRegE, RegWriteE, PCSrcE;
  logic              M_StartD, M_StartE, M_DoneE;
  logic [ADDR_W-1:0] WA3M, RA2M;
  logic              RegWriteM, MemWriteM;
  logic [ADDR_W-1:0] WA3W;
  logic              RegWriteW, MemtoRegW;
  logic              CntClr;

  logic              StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardM;
  logic              McPending;
  logic [ADDR_W-1:0] McWA;
  logic              McTimeout;
  logic [CNT_W-1:0]  LdStallCnt, McStallCnt, BrFlushCnt;

  modport master (
    output RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, MemtoRegE, RegWriteE, PCSrcE,
           M_StartD, M_StartE, M_DoneE, WA3M, RA2M, RegWriteM, MemWriteM,
           WA3W, RegWriteW, MemtoRegW, CntClr,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
           ForwardM, McPending, McWA, McTimeout, LdStallCnt, McStallCnt, BrFlushCnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, MemtoRegE, RegWriteE, PCSrcE,
           M_StartD, M_StartE, M_DoneE, WA3M, RA2M, RegWriteM, MemWriteM,
           WA3W, RegWriteW, MemtoRegW, CntClr,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
           ForwardM, McPending, McWA, McTimeout, LdStallCnt, McStallCnt, BrFlushCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use and multi-cycle write
// scoreboarding with a pending-write watchdog and saturating event counters.
module hazard_scoreboard #(
  parameter int ADDR_W     = 4,
  parameter int PC_IDX     = 15,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input logic CLK,
  input logic Reset,
  hazard_scoreboard_if.slave bus
);
  localparam int              WAIT_W = $clog2(MC_TIMEOUT) + 1;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

  logic              pendQ;
  logic [ADDR_W-1:0] pendWaQ;
  logic [WAIT_W-1:0] waitQ;
  logic              timeoutQ;
  logic [CNT_W-1:0]  ldCntQ, mcCntQ, brCntQ;

  logic ldStall, mcStall, timeoutHit;

  always_comb begin
    bus.ForwardAE = 2'b00;
    if (bus.RA1E != PcAddr) begin
      if (bus.RegWriteM && bus.RA1E == bus.WA3M)      bus.ForwardAE = 2'b10;
      else if (bus.RegWriteW && bus.RA1E == bus.WA3W) bus.ForwardAE = 2'b01;
    end
  end

  always_comb begin
    bus.ForwardBE = 2'b00;
    if (bus.RA2E != PcAddr) begin
      if (bus.RegWriteM && bus.RA2E == bus.WA3M)      bus.ForwardBE = 2'b10;
      else if (bus.RegWriteW && bus.RA2E == bus.WA3W) bus.ForwardBE = 2'b01;
    end
  end

  assign bus.ForwardM = (bus.RA2M == bus.WA3W) & bus.MemWriteM & bus.MemtoRegW &
                        bus.RegWriteW & (bus.RA2M != PcAddr);

  assign ldStall = ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E)) &
                   bus.MemtoRegE & bus.RegWriteE;
  assign mcStall = pendQ & ((bus.RA1D == pendWaQ) | (bus.RA2D == pendWaQ) |
                            (bus.WA3D == pendWaQ) | bus.M_StartD);

  // Write-back of the multi-cycle unit stalls the front end even under a branch.
  assign bus.StallF = ((ldStall | mcStall) & ~bus.PCSrcE) | bus.M_DoneE;
  assign bus.StallD = bus.StallF;
  assign bus.StallE = mcStall | bus.M_DoneE;
  assign bus.FlushD = bus.PCSrcE;
  assign bus.FlushE = ldStall | mcStall | bus.PCSrcE;
  assign bus.FlushM = bus.M_StartE;

  assign bus.McPending  = pendQ;
  assign bus.McWA       = pendWaQ;
  assign bus.McTimeout  = timeoutQ;
  assign bus.LdStallCnt = ldCntQ;
  assign bus.McStallCnt = mcCntQ;
  assign bus.BrFlushCnt = brCntQ;

  assign timeoutHit = pendQ & (waitQ == WAIT_W'(MC_TIMEOUT - 1));

  // A new launch wins over both completion and the watchdog expiring.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pendQ   <= 1'b0;
      pendWaQ <= '0;
      waitQ   <= '0;
    end else if (bus.M_StartE) begin
      pendQ   <= 1'b1;
      pendWaQ <= bus.WA3E;
      waitQ   <= '0;
    end else if (bus.M_DoneE || timeoutHit) begin
      pendQ <= 1'b0;
      waitQ <= '0;
    end else if (pendQ) begin
      waitQ <= waitQ + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      timeoutQ <= 1'b0;
      ldCntQ   <= '0;
      mcCntQ   <= '0;
      brCntQ   <= '0;
    end else if (bus.CntClr) begin
      timeoutQ <= 1'b0;
      ldCntQ   <= '0;
      mcCntQ   <= '0;
      brCntQ   <= '0;
    end else begin
      if (timeoutHit) timeoutQ <= 1'b1;
      if (ldStall && !bus.PCSrcE && ldCntQ != '1) ldCntQ <= ldCntQ + CNT_W'(1);
      if (mcStall && mcCntQ != '1)                mcCntQ <= mcCntQ + CNT_W'(1);
      if (bus.PCSrcE && brCntQ != '1)             brCntQ <= brCntQ + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by random
// traffic, all checked against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;
  localparam int AW   = 4;
  localparam int PC   = 15;
  localparam int CW   = 2;
  localparam int MCT  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(AW), .CNT_W(CW)) hif ();

  hazard_scoreboard #(.ADDR_W(AW), .PC_IDX(PC), .CNT_W(CW), .MC_TIMEOUT(MCT)) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (hif.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model state: outstanding write, its age in cycles, watchdog flag, event counts.
  bit mPend;
  int mWa, mAge;
  bit mTo;
  int mLd, mMc, mBr;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int fwdExp(input int ra);
    if (ra == PC) return 0;
    if (hif.RegWriteM && ra == int'(hif.WA3M)) return 2;
    if (hif.RegWriteW && ra == int'(hif.WA3W)) return 1;
    return 0;
  endfunction

  function automatic bit ldExp();
    return (hif.RA1D == hif.WA3E || hif.RA2D == hif.WA3E) && hif.MemtoRegE && hif.RegWriteE;
  endfunction

  function automatic bit mcExp();
    return mPend && (int'(hif.RA1D) == mWa || int'(hif.RA2D) == mWa ||
                     int'(hif.WA3D) == mWa || hif.M_StartD);
  endfunction

  function automatic int satInc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic modelReset();
    mPend = 0; mWa = 0; mAge = 0; mTo = 0; mLd = 0; mMc = 0; mBr = 0;
  endtask

  task automatic checkAll();
    bit ld, mc, br, dn, fm;
    ld = ldExp(); mc = mcExp(); br = hif.PCSrcE; dn = hif.M_DoneE;
    fm = hif.RA2M == hif.WA3W && hif.MemWriteM && hif.MemtoRegW && hif.RegWriteW && int'(hif.RA2M) != PC;
    chk("StallF", int'(hif.StallF), int'(((ld || mc) && !br) || dn));
    chk("StallD", int'(hif.StallD), int'(((ld || mc) && !br) || dn));
    chk("StallE", int'(hif.StallE), int'(mc || dn));
    chk("FlushD", int'(hif.FlushD), int'(br));
    chk("FlushE", int'(hif.FlushE), int'(ld || mc || br));
    chk("FlushM", int'(hif.FlushM), int'(hif.M_StartE));
    chk("ForwardAE", int'(hif.ForwardAE), fwdExp(int'(hif.RA1E)));
    chk("ForwardBE", int'(hif.ForwardBE), fwdExp(int'(hif.RA2E)));
    chk("ForwardM", int'(hif.ForwardM), int'(fm));
    chk("McPending", int'(hif.McPending), int'(mPend));
    chk("McWA", int'(hif.McWA), mWa);
    chk("McTimeout", int'(hif.McTimeout), int'(mTo));
    chk("LdStallCnt", int'(hif.LdStallCnt), mLd);
    chk("McStallCnt", int'(hif.McStallCnt), mMc);
    chk("BrFlushCnt", int'(hif.BrFlushCnt), mBr);
  endtask

  // Next-state of the model from the inputs presented before the clock edge.
  task automatic modelEdge();
    bit ld, mc, expired;
    if (rst) begin
      modelReset();
      return;
    end
    ld = ldExp(); mc = mcExp();
    expired = mPend && (mAge + 1 >= MCT);
    if (hif.CntClr) begin
      mLd = 0; mMc = 0; mBr = 0; mTo = 0;
    end else begin
      if (expired) mTo = 1;
      if (ld && !hif.PCSrcE) mLd = satInc(mLd);
      if (mc) mMc = satInc(mMc);
      if (hif.PCSrcE) mBr = satInc(mBr);
    end
    if (hif.M_StartE) begin
      mPend = 1; mWa = int'(hif.WA3E); mAge = 0;
    end else if (hif.M_DoneE || expired) begin
      mPend = 0; mAge = 0;
    end else if (mPend) begin
      mAge++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAll();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    hif.RA1D = '0; hif.RA2D = '0; hif.WA3D = '0;
    hif.RA1E = '0; hif.RA2E = '0; hif.WA3E = '0;
    hif.MemtoRegE = 1'b0; hif.RegWriteE = 1'b0; hif.PCSrcE = 1'b0;
    hif.M_StartD = 1'b0; hif.M_StartE = 1'b0; hif.M_DoneE = 1'b0;
    hif.WA3M = '0; hif.RA2M = '0; hif.RegWriteM = 1'b0; hif.MemWriteM = 1'b0;
    hif.WA3W = '0; hif.RegWriteW = 1'b0; hif.MemtoRegW = 1'b0;
    hif.CntClr = 1'b0;
  endtask

  function automatic logic [AW-1:0] pickAddr();
    int r;
    r = int'($urandom_range(0, 7));
    if (r < 6) return AW'(r % 4);
    if (r == 6) return AW'(PC);
    return AW'($urandom_range(0, 15));
  endfunction

  function automatic logic oneIn(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    clearIn();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend", int'(hif.McPending), 0);
    chk("rst_stallF", int'(hif.StallF), 0);
    chk("rst_ldcnt", int'(hif.LdStallCnt), 0);
    rst = 1'b0;
    cycle();

    // Load-use on RA1D
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WA3E = 4'd3; hif.RA1D = 4'd3;
    #1;
    chk("lu_stallF", int'(hif.StallF), 1);
    chk("lu_stallD", int'(hif.StallD), 1);
    chk("lu_flushE", int'(hif.FlushE), 1);
    chk("lu_stallE", int'(hif.StallE), 0);
    cycle();
    clearIn();
    chk("lu_cnt", int'(hif.LdStallCnt), 1);

    // Forward priority and PC exclusion
    hif.RA1E = 4'd5; hif.WA3M = 4'd5; hif.WA3W = 4'd5; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
    #1;
    chk("fwd_prio", int'(hif.ForwardAE), 2);
    hif.RA1E = 4'd15; hif.WA3M = 4'd15;
    #1;
    chk("fwd_pc", int'(hif.ForwardAE), 0);
    cycle();
    clearIn();

    // Scoreboard set, dependent stall, completion
    hif.M_StartE = 1'b1; hif.WA3E = 4'd7;
    cycle();
    clearIn();
    hif.RA2D = 4'd7;
    #1;
    chk("sb_pend", int'(hif.McPending), 1);
    chk("sb_wa", int'(hif.McWA), 7);
    chk("sb_stallE", int'(hif.StallE), 1);
    chk("sb_flushE", int'(hif.FlushE), 1);
    cycle();
    clearIn();
    hif.M_DoneE = 1'b1;
    #1;
    chk("done_stallE", int'(hif.StallE), 1);
    cycle();
    clearIn();
    #1;
    chk("done_pend", int'(hif.McPending), 0);
    chk("done_stallE2", int'(hif.StallE), 0);
    cycle();

    // Branch during load-use
    hif.CntClr = 1'b1;
    cycle();
    clearIn();
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WA3E = 4'd3; hif.RA2D = 4'd3; hif.PCSrcE = 1'b1;
    #1;
    chk("br_stallF", int'(hif.StallF), 0);
    chk("br_flushD", int'(hif.FlushD), 1);
    chk("br_flushE", int'(hif.FlushE), 1);
    cycle();
    clearIn();
    chk("br_brcnt", int'(hif.BrFlushCnt), 1);
    chk("br_ldcnt", int'(hif.LdStallCnt), 0);

    // Watchdog expiry after MCT pending cycles
    hif.M_StartE = 1'b1; hif.WA3E = 4'd9;
    cycle();
    clearIn();
    repeat (MCT - 1) cycle();
    chk("to_pendBefore", int'(hif.McPending), 1);
    chk("to_flagBefore", int'(hif.McTimeout), 0);
    cycle();
    chk("to_flag", int'(hif.McTimeout), 1);
    chk("to_pend", int'(hif.McPending), 0);

    // Counter saturation and clear
    hif.PCSrcE = 1'b1;
    repeat (5) cycle();
    clearIn();
    chk("sat_br", int'(hif.BrFlushCnt), CMAX);
    hif.CntClr = 1'b1;
    cycle();
    clearIn();
    chk("clr_br", int'(hif.BrFlushCnt), 0);
    chk("clr_ld", int'(hif.LdStallCnt), 0);
    chk("clr_to", int'(hif.McTimeout), 0);

    // Asynchronous reset while a write is pending
    hif.M_StartE = 1'b1; hif.WA3E = 4'd2;
    cycle();
    clearIn();
    hif.RA1D = 4'd2;
    #1;
    chk("ar_stallE", int'(hif.StallE), 1);
    rst = 1'b1;
    #1;
    chk("ar_pend", int'(hif.McPending), 0);
    chk("ar_stallE2", int'(hif.StallE), 0);
    modelReset();
    cycle();
    rst = 1'b0;
    clearIn();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      hif.RA1D = pickAddr(); hif.RA2D = pickAddr(); hif.WA3D = pickAddr();
      hif.RA1E = pickAddr(); hif.RA2E = pickAddr(); hif.WA3E = pickAddr();
      hif.WA3M = pickAddr(); hif.RA2M = pickAddr(); hif.WA3W = pickAddr();
      hif.MemtoRegE = oneIn(2); hif.RegWriteE = oneIn(2); hif.PCSrcE = oneIn(6);
      hif.M_StartD = oneIn(6); hif.M_StartE = oneIn(8); hif.M_DoneE = oneIn(8);
      hif.RegWriteM = oneIn(2); hif.MemWriteM = oneIn(2);
      hif.RegWriteW = oneIn(2); hif.MemtoRegW = oneIn(2);
      hif.CntClr = oneIn(40);
      rst = oneIn(200);
      if (rst) modelReset();
      cycle();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: register-address width; register file holds 2**ADDR_W entries.
REQ-002 SHALL have parameter PC_IDX, default 15: index of the PC register, which is never a forwarding source.
REQ-003 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-004 SHALL have parameter MC_TIMEOUT, default 64: maximum cycles a multi-cycle write may stay pending.
REQ-005 SHALL have ports (name direction width meaning):
- CLK  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RA1D, RA2D, WA3D  in  ADDR_W  decode-stage read and write addresses.
- RA1E, RA2E, WA3E  in  ADDR_W  execute-stage addresses.
- MemtoRegE, RegWriteE, PCSrcE  in  1  execute-stage control.
- M_StartD  in  1  decode stage holds a multi-cycle op.
- M_StartE  in  1  multi-cycle op launches this cycle from E.
- M_DoneE  in  1  multi-cycle unit writes back this cycle.
- WA3M, RA2M  in  ADDR_W  memory-stage addresses.
- RegWriteM, MemWriteM  in  1  memory-stage control.
- WA3W  in  ADDR_W  writeback address.
- RegWriteW, MemtoRegW  in  1  writeback control.
- CntClr  in  1  synchronous clear of the counters and timeout flag.
- StallF, StallD, StallE, FlushD, FlushE, FlushM  out  1  pipeline control.
- ForwardAE, ForwardBE  out  2  operand select: 10 = M, 01 = W, 00 = register file.
- ForwardM  out  1  store-data forward from W.
- McPending  out  1  a multi-cycle write is outstanding.
- McWA  out  ADDR_W  destination of the outstanding write.
- McTimeout  out  1  sticky watchdog flag.
- LdStallCnt, McStallCnt, BrFlushCnt  out  CNT_W  saturating event counters.

Function
REQ-006 SHALL drive ForwardAE = 10 when RA1E == WA3M and RegWriteM; else 01 when RA1E == WA3W and RegWriteW; else 00. The output SHALL be forced to 00 when RA1E == PC_IDX. ForwardBE SHALL follow the same rule using RA2E.
REQ-007 SHALL drive ForwardM = (RA2M == WA3W) & MemWriteM & MemtoRegW & RegWriteW & (RA2M != PC_IDX).
REQ-008 SHALL compute LdStall = (RA1D == WA3E | RA2D == WA3E) & MemtoRegE & RegWriteE.
REQ-009 SHALL hold registers pend_q (1 bit) and pend_wa_q (ADDR_W bits) as the scoreboard.
REQ-010 SHALL, on a clock edge with M_StartE = 1, set pend_q = 1 and pend_wa_q = WA3E; this takes priority over a same-cycle M_DoneE clear.
REQ-011 SHALL, on a clock edge with M_DoneE = 1 and M_StartE = 0, clear pend_q.
REQ-012 SHALL compute McStall = pend_q & (RA1D == pend_wa_q | RA2D == pend_wa_q | WA3D == pend_wa_q | M_StartD).
REQ-013 SHALL drive StallF = StallD = ((LdStall | McStall) & ~PCSrcE) | M_DoneE.
REQ-014 SHALL drive StallE = McStall | M_DoneE.
REQ-015 SHALL drive FlushD = PCSrcE, FlushE = LdStall | McStall | PCSrcE, and FlushM = M_StartE.
REQ-016 SHALL drive McPending = pend_q and McWA = pend_wa_q; all stall, flush and forward outputs SHALL be combinational, with zero-cycle latency.
REQ-017 SHALL count wait_q cycles while pend_q = 1, restarting from 0 on every set of pend_q.
REQ-018 SHALL, when wait_q reaches MC_TIMEOUT - 1 with pend_q = 1, set McTimeout on the next edge and clear pend_q. McTimeout stays set until Reset or CntClr.
REQ-019 SHALL increment LdStallCnt on each cycle with LdStall & ~PCSrcE, McStallCnt on each cycle with McStall, and BrFlushCnt on each cycle with PCSrcE.
REQ-020 SHALL hold each counter at all-ones once reached (saturating, no wrap).
REQ-021 SHALL, on CntClr, zero all three counters and McTimeout on the next edge; CntClr SHALL take priority over a same-cycle increment and leave the scoreboard untouched.

Reset
REQ-022 SHALL, while Reset = 1, asynchronously force pend_q = 0, pend_wa_q = 0, wait_q = 0, McTimeout = 0 and all counters = 0.
REQ-023 SHALL, with all inputs at 0 after reset, drive every combinational output to 0.
REQ-024 SHALL, on Reset asserted mid-operation, drop any pending multi-cycle write with no further stall.

Verification
REQ-025 Load-use: MemtoRegE = RegWriteE = 1, WA3E = 3, RA1D = 3 -> StallF = StallD = FlushE = 1, StallE = 0; LdStallCnt increments by 1.
REQ-026 Forward priority: RA1E = 5, WA3M = WA3W = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10; with RA1E = WA3M = 15 -> ForwardAE = 00.
REQ-027 Scoreboard: M_StartE with WA3E = 7; next cycle RA2D = 7 -> McPending = 1, McWA = 7, StallE = FlushE = 1; M_DoneE pulse -> stall that cycle only, then McPending = 0.
REQ-028 Branch during load-use: PCSrcE = 1 together with LdStall -> StallF = 0, FlushD = FlushE = 1; BrFlushCnt increments and LdStallCnt does not.
REQ-029 Timeout and saturation: MC_TIMEOUT = 4 with no M_DoneE -> McTimeout = 1 and McPending = 0 after 4 pending cycles; with CNT_W = 2, five branch cycles -> BrFlushCnt = 3; CntClr -> all counters = 0.
